// File: rtl/instruction_fetch_unit_if.sv
// Instruction-cache port of the fetch unit: read request/address out, word/busywait back.
// The master modport is the fetch unit, the slave modport is the instruction cache.
interface instruction_fetch_unit_if;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_readdata;
    logic        imem_busywait;

    modport master (
        output imem_read,
        output imem_address,
        input  imem_readdata,
        input  imem_busywait
    );

    modport slave (
        input  imem_read,
        input  imem_address,
        output imem_readdata,
        output imem_busywait
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Pipeline fetch stage: PC register, cache read request and branch redirect FSM.
// Define IF_MISALIGN_CHECK_EN to add the sticky misalign_fault output and align redirect targets.
module instruction_fetch_unit (
    input  logic                             CLK,
    input  logic                             reset,
    input  logic                             stall,
    input  logic                             branch_taken,
    input  logic [31:0]                      branch_target,
    instruction_fetch_unit_if.master         imem,
    output logic [31:0]                      OUT_pc,
    output logic [31:0]                      OUT_pc_plus_4,
    output logic [31:0]                      OUT_instruction,
    output logic                             busywait
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic                             misalign_fault
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_REDIRECT
    } state_t;

    state_t      state;
    logic        read_q;
    logic [31:0] pc;
    logic [31:0] redirect_pc;
    logic [31:0] target_eff;

`ifdef IF_MISALIGN_CHECK_EN
    logic fault_q;

    assign target_eff     = {branch_target[31:2], 2'b00};
    assign misalign_fault = fault_q;

    always_ff @(posedge CLK) begin
        if (reset)
            fault_q <= 1'b0;
        else if (state == S_FETCH && branch_taken && (branch_target[1:0] != 2'b00))
            fault_q <= 1'b1;
    end
`else
    assign target_eff = branch_target;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= S_IDLE;
            read_q      <= 1'b0;
            pc          <= '0;
            redirect_pc <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state  <= S_FETCH;
                    read_q <= 1'b1;
                end
                S_FETCH: begin
                    if (branch_taken) begin
                        // A redirect during a miss is parked until the cache releases the old fetch.
                        if (imem.imem_busywait) begin
                            redirect_pc <= target_eff;
                            state       <= S_REDIRECT;
                        end else begin
                            pc <= target_eff;
                        end
                    end else if (!imem.imem_busywait && !stall) begin
                        pc <= pc + 32'd4;
                    end
                end
                S_REDIRECT: begin
                    if (!imem.imem_busywait) begin
                        pc    <= redirect_pc;
                        state <= S_FETCH;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    read_q <= 1'b0;
                end
            endcase
        end
    end

    // Reset gates the outputs directly so they are defined even before the first reset edge.
    assign OUT_pc            = reset ? 32'd0 : pc;
    assign OUT_pc_plus_4     = OUT_pc + 32'd4;
    assign imem.imem_address = OUT_pc;
    assign imem.imem_read    = read_q && !reset;
    assign busywait          = !reset && (state != S_IDLE) && imem.imem_busywait;

    // NOTE: the default assignment first keeps this always_comb from inferring a latch.
    always_comb begin
        OUT_instruction = imem.imem_readdata;
        if (reset || state == S_IDLE || state == S_REDIRECT ||
            (state == S_FETCH && branch_taken))
            OUT_instruction = NOP;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed per-cycle vectors push expected
// outputs into a queue; a negedge monitor pops and compares them against the DUT.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        string       name;
        logic        read;
        logic        bw;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic        CLK = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] OUT_pc;
    logic [31:0] OUT_pc_plus_4;
    logic [31:0] OUT_instruction;
    logic        busywait;
`ifdef IF_MISALIGN_CHECK_EN
    logic        misalign_fault;
`endif

    int checks   = 0;
    int failures = 0;
    exp_t sb_q[$];

    instruction_fetch_unit_if imem ();

    instruction_fetch_unit dut (
        .CLK             (CLK),
        .reset           (reset),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem            (imem),
        .OUT_pc          (OUT_pc),
        .OUT_pc_plus_4   (OUT_pc_plus_4),
        .OUT_instruction (OUT_instruction),
        .busywait        (busywait)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .misalign_fault  (misalign_fault)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // One cycle of stimulus: drive after the rising edge, then queue what the DUT should show.
    task automatic cyc(input string name, input logic rst, input logic stl, input logic br,
                       input logic [31:0] tgt, input logic bw_in, input logic [31:0] rdata,
                       input logic e_read, input logic e_bw, input logic [31:0] e_pc,
                       input logic [31:0] e_instr, input logic e_fault);
        exp_t e;
        @(posedge CLK);
        #1;
        reset                = rst;
        stall                = stl;
        branch_taken         = br;
        branch_target        = tgt;
        imem.imem_busywait   = bw_in;
        imem.imem_readdata   = rdata;
        e.name  = name;
        e.read  = e_read;
        e.bw    = e_bw;
        e.pc    = e_pc;
        e.instr = e_instr;
        e.fault = e_fault;
        sb_q.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.name, ".imem_read"},    {31'd0, imem.imem_read}, {31'd0, e.read});
            check({e.name, ".busywait"},     {31'd0, busywait},       {31'd0, e.bw});
            check({e.name, ".OUT_pc"},       OUT_pc,                  e.pc);
            check({e.name, ".imem_address"}, imem.imem_address,       e.pc);
            check({e.name, ".pc_plus_4"},    OUT_pc_plus_4,           e.pc + 32'd4);
            check({e.name, ".instruction"},  OUT_instruction,         e.instr);
`ifdef IF_MISALIGN_CHECK_EN
            check({e.name, ".misalign"},     {31'd0, misalign_fault}, {31'd0, e.fault});
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cycles;
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        imem.imem_busywait = 1'b0; imem.imem_readdata = '0;

        //   name          rst stl br  target        bw  rdata          read bw  pc            instr          fault
        cyc("rst0",        1, 0, 0, 32'h0,        0, 32'hAAAA0000, 0, 0, 32'h0,        NOP,           0);
        cyc("rst1",        1, 0, 0, 32'h0,        1, 32'hAAAA0000, 0, 0, 32'h0,        NOP,           0);
        cyc("idle",        0, 0, 0, 32'h0,        0, 32'hAAAA0001, 0, 0, 32'h0,        NOP,           0);
        cyc("fetch0",      0, 0, 0, 32'h0,        0, 32'h11111111, 1, 0, 32'h0,        32'h11111111,  0);
        cyc("fetch4",      0, 0, 0, 32'h0,        0, 32'h22222222, 1, 0, 32'h4,        32'h22222222,  0);
        cyc("miss1",       0, 0, 0, 32'h0,        1, 32'h33333333, 1, 1, 32'h8,        32'h33333333,  0);
        cyc("miss2",       0, 0, 0, 32'h0,        1, 32'h33333333, 1, 1, 32'h8,        32'h33333333,  0);
        cyc("miss3",       0, 0, 0, 32'h0,        1, 32'h33333333, 1, 1, 32'h8,        32'h33333333,  0);
        cyc("miss4",       0, 0, 0, 32'h0,        1, 32'h33333333, 1, 1, 32'h8,        32'h33333333,  0);
        cyc("release",     0, 0, 0, 32'h0,        0, 32'h44444444, 1, 0, 32'h8,        32'h44444444,  0);
        cyc("br_hit",      0, 0, 1, 32'h100,      0, 32'h45454545, 1, 0, 32'hC,        NOP,           0);
        cyc("at100",       0, 0, 0, 32'h0,        0, 32'h55555555, 1, 0, 32'h100,      32'h55555555,  0);
        cyc("br_miss",     0, 0, 1, 32'h200,      1, 32'h56565656, 1, 1, 32'h104,      NOP,           0);
        cyc("redir_hold",  0, 0, 1, 32'h999,      1, 32'h66666666, 1, 1, 32'h104,      NOP,           0);
        cyc("redir_rel",   0, 0, 0, 32'h0,        0, 32'h67676767, 1, 0, 32'h104,      NOP,           0);
        cyc("stall1",      0, 1, 0, 32'h0,        0, 32'h77777777, 1, 0, 32'h200,      32'h77777777,  0);
        cyc("stall2",      0, 1, 0, 32'h0,        0, 32'h78787878, 1, 0, 32'h200,      32'h78787878,  0);
        cyc("stall_br",    0, 1, 1, 32'h40,       0, 32'h79797979, 1, 0, 32'h200,      NOP,           0);
        cyc("at40",        0, 0, 0, 32'h0,        0, 32'h88888888, 1, 0, 32'h40,       32'h88888888,  0);
        cyc("br_pend",     0, 0, 1, 32'h300,      1, 32'h89898989, 1, 1, 32'h44,       NOP,           0);
        cyc("rst_redir",   1, 0, 0, 32'h0,        1, 32'h8A8A8A8A, 0, 0, 32'h0,        NOP,           0);
        cyc("idle2",       0, 0, 0, 32'h0,        1, 32'h8B8B8B8B, 0, 0, 32'h0,        NOP,           0);
        cyc("refetch0",    0, 0, 0, 32'h0,        0, 32'h99999999, 1, 0, 32'h0,        32'h99999999,  0);
        cyc("br_top",      0, 0, 1, 32'hFFFFFFFC, 0, 32'h9A9A9A9A, 1, 0, 32'h4,        NOP,           0);
        cyc("at_top",      0, 0, 0, 32'h0,        0, 32'hBBBBBBBB, 1, 0, 32'hFFFFFFFC, 32'hBBBBBBBB,  0);
        cyc("wrapped",     0, 0, 0, 32'h0,        0, 32'hCCCCCCCC, 1, 0, 32'h0,        32'hCCCCCCCC,  0);
        cyc("br_odd",      0, 0, 1, 32'h102,      0, 32'hCDCDCDCD, 1, 0, 32'h4,        NOP,           0);
`ifdef IF_MISALIGN_CHECK_EN
        cyc("at_aligned",  0, 0, 0, 32'h0,        0, 32'hDDDDDDDD, 1, 0, 32'h100,      32'hDDDDDDDD,  1);
        cyc("fault_stick", 0, 0, 0, 32'h0,        0, 32'hEEEEEEEE, 1, 0, 32'h104,      32'hEEEEEEEE,  1);
        cyc("fault_rst",   1, 0, 0, 32'h0,        0, 32'hEEEEEEEE, 0, 0, 32'h0,        NOP,           1);
        cyc("fault_clr",   0, 0, 0, 32'h0,        0, 32'hEEEEEEEE, 0, 0, 32'h0,        NOP,           0);
`else
        cyc("at_odd",      0, 0, 0, 32'h0,        0, 32'hDDDDDDDD, 1, 0, 32'h102,      32'hDDDDDDDD,  0);
        cyc("after_odd",   0, 0, 0, 32'h0,        0, 32'hEEEEEEEE, 1, 0, 32'h106,      32'hEEEEEEEE,  0);
`endif

        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 10) begin
            @(posedge CLK);
            wait_cycles++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have port CLK, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset, sampled on rising CLK.
REQ-003 SHALL have port stall, input, 1, hazard-unit hold request; PC frozen while high.
REQ-004 SHALL have port branch_taken, input, 1, redirect request from execute stage.
REQ-005 SHALL have port branch_target, input, 32, redirect address, valid while branch_taken=1.
REQ-006 SHALL have port imem_readdata, input, 32, instruction word from instruction cache.
REQ-007 SHALL have port imem_busywait, input, 1, instruction cache not ready.
REQ-008 SHALL have port imem_read, output, 1, read request to instruction cache.
REQ-009 SHALL have port imem_address, output, 32, fetch address, equal to OUT_pc.
REQ-010 SHALL have port OUT_pc, output, 32, address of fetched instruction, to IF/ID register.
REQ-011 SHALL have port OUT_pc_plus_4, output, 32, OUT_pc+4, to IF/ID register.
REQ-012 SHALL have port OUT_instruction, output, 32, fetched word or NOP, to IF/ID register.
REQ-013 SHALL have port busywait, output, 1, pipeline freeze to all pipeline registers.

Function
REQ-014 SHALL implement FSM states S_IDLE, S_FETCH, S_REDIRECT.
REQ-015 S_IDLE SHALL hold imem_read=0, OUT_instruction=0x00000013, and move to S_FETCH on the next rising CLK.
REQ-016 S_FETCH SHALL hold imem_read=1 and imem_address=OUT_pc.
REQ-017 In S_FETCH with imem_busywait=0, stall=0, branch_taken=0, the PC SHALL advance to OUT_pc+4 on rising CLK.
REQ-018 In S_FETCH with imem_busywait=0 and branch_taken=1, the PC SHALL load branch_target on rising CLK, and OUT_instruction SHALL read 0x00000013 in that cycle.
REQ-019 branch_taken SHALL take priority over stall; reset SHALL take priority over everything.
REQ-020 In S_FETCH with stall=1 and branch_taken=0, the PC SHALL hold, and OUT_instruction SHALL keep showing the current imem_readdata.
REQ-021 In S_FETCH with imem_busywait=1 and branch_taken=1, the unit SHALL latch branch_target into a redirect register and enter S_REDIRECT; the PC SHALL hold.
REQ-022 S_REDIRECT SHALL keep imem_read=1 at the old PC, force OUT_instruction=0x00000013, and ignore further branch_taken.
REQ-023 When imem_busywait falls in S_REDIRECT, the PC SHALL load the redirect register on rising CLK and the FSM SHALL return to S_FETCH.
REQ-024 busywait SHALL equal imem_busywait in S_FETCH and S_REDIRECT and SHALL be 0 in S_IDLE.
REQ-025 OUT_pc_plus_4 SHALL equal OUT_pc+4 combinationally, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-026 OUT_instruction SHALL equal imem_readdata whenever it is not forced to NOP.

Reset
REQ-027 On rising CLK with reset=1, the unit SHALL set the PC to 0x00000000, clear the redirect register, and enter S_IDLE.
REQ-028 Reset SHALL abort any in-flight fetch or pending redirect; the pending target SHALL be discarded.
REQ-029 While reset=1, outputs SHALL be: imem_read=0, busywait=0, OUT_pc=0, OUT_pc_plus_4=4, OUT_instruction=0x00000013.

Configuration
REQ-030 Macro IF_MISALIGN_CHECK_EN SHALL add output port misalign_fault, 1 bit.
REQ-031 With IF_MISALIGN_CHECK_EN defined, a redirect target with bits[1:0]!=0 SHALL set misalign_fault=1 (sticky until reset). The PC SHALL load the target with bits[1:0] cleared.
REQ-032 With IF_MISALIGN_CHECK_EN undefined, the port SHALL be absent, and branch_target SHALL load unmodified.

Verification
REQ-033 Reset, then 3 cycles with busywait low -> S_IDLE one cycle; OUT_pc=0x0, then 0x4, imem_read=1.
REQ-034 Cache miss: imem_busywait high 4 cycles at PC 0x8 -> PC holds 0x8, busywait=1 for 4 cycles, PC=0xC on the first cycle after release.
REQ-035 branch_taken=1, target 0x100, no busywait -> next OUT_pc=0x100; OUT_instruction=0x00000013 in the redirect cycle.
REQ-036 branch_taken=1, target 0x200, during busywait -> S_REDIRECT, NOP output; when busywait drops, OUT_pc=0x200 on the next cycle.
REQ-037 stall=1 and branch_taken=1 together, target 0x40 -> PC loads 0x40; with stall alone, PC holds for every stalled cycle.
REQ-038 reset asserted in S_REDIRECT with pending target 0x300 -> OUT_pc=0x0 and the target is never fetched; with IF_MISALIGN_CHECK_EN, target 0x102 -> OUT_pc=0x100 and misalign_fault=1.
